// File: rtl/wrf_arb_pkg.sv
// Shared types, widths and the round-robin search for the WR fabric sink arbiter.
package wrf_arb_pkg;

    localparam int WRF_DAT_W = 16;
    localparam int WRF_ADR_W = 2;
    localparam int WRF_SEL_W = 2;
    localparam int MAX_SRC   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } wrf_arb_state_e;

    // Returns {found, index} of the first request at or after ptr, wrapping at n_src.
    function automatic logic [2:0] rr_first(input logic [MAX_SRC-1:0] req,
                                            input logic [1:0]         ptr,
                                            input int                 n_src);
        logic       found;
        logic [1:0] idx;
        logic [1:0] sel;
        found = 1'b0;
        sel   = 2'd0;
        for (int k = 0; k < MAX_SRC; k++) begin
            idx = 2'((int'(ptr) + k) % n_src);
            if (k < n_src && !found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return {found, sel};
    endfunction

endpackage

// File: rtl/wrf_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first request at or after i_ptr.
module wrf_rr_pick
    import wrf_arb_pkg::*;
#(
    parameter int N_SRC = 2
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [1:0]       i_ptr,
    output logic [N_SRC-1:0] o_gnt
);

    logic [MAX_SRC-1:0] w_req_ext;
    logic [2:0]         w_pick;

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[N_SRC-1:0]   = i_req;
    end

    assign w_pick = rr_first(w_req_ext, i_ptr, N_SRC);

    always_comb begin
        o_gnt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_pick[2] && w_pick[1:0] == 2'(i)) o_gnt[i] = 1'b1;
        end
    end

endmodule

// File: rtl/wrf_snk_arbiter.sv
// Frame-level round-robin arbiter sharing one WR fabric sink among N_SRC sources.
// Optional watchdog enabled by defining WRF_ARB_WATCHDOG_EN.
//
//   state    | meaning
//   ST_IDLE  | bus released, cyc low, picking next requester
//   ST_GRANT | owner drives stb/adr/dat/sel, acks and stalls routed back
//   ST_DRAIN | owner dropped cyc, waiting for outstanding acks with stb low
module wrf_snk_arbiter
    import wrf_arb_pkg::*;
#(
    parameter int N_SRC       = 2,
    parameter int OUTST_W     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       wr_sys_clk,
    input  logic                       wr_sys_rst_n,
    input  logic [N_SRC-1:0]           src_cyc,
    input  logic [N_SRC-1:0]           src_stb,
    input  logic [WRF_ADR_W*N_SRC-1:0] src_adr,
    input  logic [WRF_DAT_W*N_SRC-1:0] src_dat,
    input  logic [WRF_SEL_W*N_SRC-1:0] src_sel,
    output logic [N_SRC-1:0]           src_ack,
    output logic [N_SRC-1:0]           src_stall,
    output logic [WRF_ADR_W-1:0]       wrf_snk_adr,
    output logic [WRF_DAT_W-1:0]       wrf_snk_dat,
    output logic                       wrf_snk_cyc,
    output logic                       wrf_snk_stb,
    output logic [WRF_SEL_W-1:0]       wrf_snk_sel,
    output logic                       wrf_snk_we,
    input  logic                       wrf_snk_ack,
    input  logic                       wrf_snk_stall,
    output logic [N_SRC-1:0]           grant,
    output logic                       frame_done,
    output logic                       timeout_err
);

    localparam logic [OUTST_W-1:0] OUTST_MAX = '1;

    if (N_SRC < 2 || N_SRC > MAX_SRC || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("wrf_snk_arbiter: unsupported N_SRC/TIMEOUT_CYC");
    end

    wrf_arb_state_e       r_state;
    logic [N_SRC-1:0]     r_grant;
    logic [1:0]           r_owner;
    logic [1:0]           r_rr_ptr;
    logic [OUTST_W-1:0]   r_outst;
    logic                 r_frame_done;

    logic [OUTST_W-1:0]   w_outst_nxt;
    logic [N_SRC-1:0]     w_req;
    logic [N_SRC-1:0]     w_pick;
    logic [1:0]           w_pick_idx;
    logic                 w_busy, w_full, w_inc, w_dec, w_release, w_timeout;
    logic                 w_own_cyc, w_own_stb;
    logic [WRF_ADR_W-1:0] w_adr;
    logic [WRF_DAT_W-1:0] w_dat;
    logic [WRF_SEL_W-1:0] w_sel;

    wrf_rr_pick #(.N_SRC(N_SRC)) u_pick (
        .i_req (w_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick)
    );

    always_comb begin
        w_pick_idx = 2'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_pick[i]) w_pick_idx = 2'(i);
        end
    end

    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_adr     = '0;
        w_dat     = '0;
        w_sel     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_owner == 2'(i)) begin
                w_own_cyc = src_cyc[i];
                w_own_stb = src_stb[i];
                w_adr     = src_adr[i*WRF_ADR_W +: WRF_ADR_W];
                w_dat     = src_dat[i*WRF_DAT_W +: WRF_DAT_W];
                w_sel     = src_sel[i*WRF_SEL_W +: WRF_SEL_W];
            end
        end
    end

    assign w_busy      = (r_state != ST_IDLE);
    assign w_full      = (r_outst == OUTST_MAX);
    assign wrf_snk_cyc = w_busy;
    // A strobe is only forwarded while the owner still holds cyc.
    assign wrf_snk_stb = (r_state == ST_GRANT) & w_own_cyc & w_own_stb & ~w_full;
    assign wrf_snk_adr = w_busy ? w_adr : '0;
    assign wrf_snk_dat = w_busy ? w_dat : '0;
    assign wrf_snk_sel = w_busy ? w_sel : '0;
    assign wrf_snk_we  = 1'b1;
    assign grant       = r_grant;
    assign frame_done  = r_frame_done;

    always_comb begin
        src_ack   = '0;
        src_stall = '1;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_busy && r_owner == 2'(i)) begin
                src_ack[i]   = wrf_snk_ack;
                src_stall[i] = (r_state == ST_DRAIN) | wrf_snk_stall | w_full;
            end
        end
    end

    assign w_inc = wrf_snk_stb & ~wrf_snk_stall;
    assign w_dec = w_busy & wrf_snk_ack & (r_outst != '0);

    always_comb begin
        w_outst_nxt = r_outst;
        if (w_inc && !w_dec)      w_outst_nxt = r_outst + 1'b1;
        else if (!w_inc && w_dec) w_outst_nxt = r_outst - 1'b1;
    end

    // Release once nothing is left in flight, looking at this cycle's ack too.
    assign w_release = ((r_state == ST_GRANT) & ~w_own_cyc & (w_outst_nxt == '0))
                     | ((r_state == ST_DRAIN) & (w_outst_nxt == '0))
                     | w_timeout;

`ifdef WRF_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0]  r_wd_cnt;
    logic             r_timeout_err;
    logic [N_SRC-1:0] r_blocked;
    logic             w_wd_act;

    assign w_wd_act    = w_inc | (w_busy & wrf_snk_ack);
    assign w_timeout   = w_busy & ~w_wd_act & (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign timeout_err = r_timeout_err;
    assign w_req       = src_cyc & ~r_blocked;

    always_ff @(posedge wr_sys_clk or negedge wr_sys_rst_n) begin
        if (!wr_sys_rst_n) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
            r_blocked     <= '0;
        end else begin
            if (!w_busy || w_wd_act) r_wd_cnt <= '0;
            else                     r_wd_cnt <= r_wd_cnt + 1'b1;
            if (w_timeout) r_timeout_err <= 1'b1;
            // A timed-out owner is ignored until it lets go of cyc.
            for (int i = 0; i < N_SRC; i++) begin
                if (w_timeout && r_owner == 2'(i)) r_blocked[i] <= 1'b1;
                else if (!src_cyc[i])              r_blocked[i] <= 1'b0;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
    assign w_req       = src_cyc;
`endif

    always_ff @(posedge wr_sys_clk or negedge wr_sys_rst_n) begin
        if (!wr_sys_rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_owner      <= 2'd0;
            r_rr_ptr     <= 2'd0;
            r_outst      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_outst      <= w_outst_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (|w_pick) begin
                        r_state <= ST_GRANT;
                        r_grant <= w_pick;
                        r_owner <= w_pick_idx;
                    end
                end
                ST_GRANT, ST_DRAIN: begin
                    if (w_release) begin
                        r_state      <= ST_IDLE;
                        r_grant      <= '0;
                        r_frame_done <= 1'b1;
                        r_rr_ptr     <= (r_owner == 2'(N_SRC - 1)) ? 2'd0 : r_owner + 2'd1;
                        if (w_timeout) r_outst <= '0;
                    end else if (r_state == ST_GRANT && !w_own_cyc) begin
                        r_state <= ST_DRAIN;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
